// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - round-robin arbiter sharing one I2C master engine; optional watchdog via I2C_ARB_TIMEOUT_EN
module i2c_master_arbiter #(
    parameter int         NUM_REQ        = 3,
    parameter logic [7:0] DEV_ADDR_W     = 8'hC0,
    parameter int         TIMEOUT_CYCLES = 500000
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ-1:0]     i_rw,
    input  logic [16*NUM_REQ-1:0]  i_addr,
    input  logic [8*NUM_REQ-1:0]   i_wdata,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic [NUM_REQ-1:0]     o_ack,
    output logic [7:0]             o_rdata,
    output logic                   o_err,
    output logic                   o_mst_write,
    output logic                   o_mst_read,
    output logic [7:0]             o_slave_addr,
    output logic [7:0]             o_cmd_byte,
    output logic [7:0]             o_num_bytes,
    output logic [31:0]            o_din,
    input  logic                   i_busy,
    input  logic                   i_data_out_valid,
    input  logic [31:0]            i_data_out,
    input  logic                   i_rxak,
    input  logic                   i_arb_lost,
    output logic                   o_arb_lost_clr,
    output logic                   o_soft_rst
);

    localparam int LG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE, WR_ISSUE, WR_BUSY, WR_DONE, RD_ISSUE, RD_BUSY, RD_DONE, RESP
    } state_t;

    state_t             state_q;
    logic [LG_W-1:0]    last_grant_q;
    logic [LG_W-1:0]    owner_q;
    logic               rw_q;
    logic [7:0]         rd_byte_q;
    logic               rd_seen_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [7:0]         rdata_q;
    logic               err_q;
    logic               mst_write_q;
    logic               mst_read_q;
    logic [7:0]         slave_addr_q;
    logic [7:0]         cmd_byte_q;
    logic [7:0]         num_bytes_q;
    logic [31:0]        din_q;
    logic               arb_lost_clr_q;

    logic               sel_valid_d;
    logic [LG_W-1:0]    sel_idx_d;
    logic [LG_W-1:0]    cand_d;
    logic [NUM_REQ-1:0] sel_oh_d;
    logic               sel_rw_d;
    logic [15:0]        sel_addr_d;
    logic [7:0]         sel_wdata_d;
    logic               rd_ok_d;
    logic [7:0]         rd_byte_d;
    logic               tmo_hit;
    logic               unused_hi;

    assign unused_hi = ^i_data_out[31:8];

    // Rotating priority search: first pending request after the last owner
    always_comb begin
        sel_valid_d = 1'b0;
        sel_idx_d   = '0;
        cand_d      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_d = LG_W'((int'(last_grant_q) + i) % NUM_REQ);
            if (!sel_valid_d && i_req[cand_d]) begin
                sel_valid_d = 1'b1;
                sel_idx_d   = cand_d;
            end
        end
    end

    // Payload mux for the selected requester
    always_comb begin
        sel_oh_d    = '0;
        sel_rw_d    = 1'b0;
        sel_addr_d  = '0;
        sel_wdata_d = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_idx_d == LG_W'(k)) begin
                sel_oh_d[k] = 1'b1;
                sel_rw_d    = i_rw[k];
                sel_addr_d  = i_addr[16*k +: 16];
                sel_wdata_d = i_wdata[8*k +: 8];
            end
        end
    end

    // A byte arriving in the same cycle busy drops still counts
    assign rd_ok_d   = rd_seen_q | i_data_out_valid;
    assign rd_byte_d = i_data_out_valid ? i_data_out[7:0] : rd_byte_q;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_q;
    logic             soft_rst_q;
    logic             in_wait;

    assign in_wait = (state_q == WR_BUSY) || (state_q == WR_DONE) ||
                     (state_q == RD_BUSY) || (state_q == RD_DONE);
    assign tmo_hit = in_wait && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: restart at each issue, count while waiting on the master
    always_ff @(posedge clk) begin
        if (i_rst) begin
            tmo_q <= '0;
        end else if (state_q == WR_ISSUE || state_q == RD_ISSUE) begin
            tmo_q <= '0;
        end else if (in_wait) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    // Soft-reset pulse coincides with the RESP cycle of a timed-out op
    always_ff @(posedge clk) begin
        if (i_rst) begin
            soft_rst_q <= 1'b0;
        end else begin
            soft_rst_q <= tmo_hit;
        end
    end

    assign o_soft_rst = soft_rst_q;
`else
    logic unused_tmo;

    assign unused_tmo = (TIMEOUT_CYCLES == 0);
    assign tmo_hit    = 1'b0;
    assign o_soft_rst = 1'b0;
`endif

    // Arbitration and I2C command/handshake sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q        <= IDLE;
            last_grant_q   <= LG_W'(NUM_REQ - 1);
            owner_q        <= '0;
            rw_q           <= 1'b0;
            rd_byte_q      <= '0;
            rd_seen_q      <= 1'b0;
            grant_q        <= '0;
            ack_q          <= '0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            mst_write_q    <= 1'b0;
            mst_read_q     <= 1'b0;
            slave_addr_q   <= '0;
            cmd_byte_q     <= '0;
            num_bytes_q    <= '0;
            din_q          <= '0;
            arb_lost_clr_q <= 1'b0;
        end else begin
            mst_write_q    <= 1'b0;
            mst_read_q     <= 1'b0;
            ack_q          <= '0;
            arb_lost_clr_q <= 1'b0;
            if (tmo_hit) begin
                err_q          <= 1'b1;
                rdata_q        <= '0;
                ack_q          <= grant_q;
                arb_lost_clr_q <= i_arb_lost;
                state_q        <= RESP;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (sel_valid_d) begin
                            grant_q      <= sel_oh_d;
                            owner_q      <= sel_idx_d;
                            rw_q         <= sel_rw_d;
                            mst_write_q  <= 1'b1;
                            slave_addr_q <= DEV_ADDR_W;
                            cmd_byte_q   <= sel_addr_d[15:8];
                            if (sel_rw_d) begin
                                num_bytes_q <= 8'd1;
                                din_q       <= {24'h0, sel_addr_d[7:0]};
                            end else begin
                                num_bytes_q <= 8'd2;
                                din_q       <= {16'h0, sel_wdata_d, sel_addr_d[7:0]};
                            end
                            state_q <= WR_ISSUE;
                        end
                    end
                    WR_ISSUE: state_q <= WR_BUSY;
                    WR_BUSY: begin
                        if (i_busy) state_q <= WR_DONE;
                    end
                    WR_DONE: begin
                        if (!i_busy) begin
                            if (i_rxak || i_arb_lost || !rw_q) begin
                                err_q          <= i_rxak | i_arb_lost;
                                rdata_q        <= '0;
                                ack_q          <= grant_q;
                                arb_lost_clr_q <= i_arb_lost;
                                state_q        <= RESP;
                            end else begin
                                mst_read_q   <= 1'b1;
                                slave_addr_q <= DEV_ADDR_W | 8'h01;
                                num_bytes_q  <= 8'd1;
                                rd_seen_q    <= 1'b0;
                                state_q      <= RD_ISSUE;
                            end
                        end
                    end
                    RD_ISSUE: state_q <= RD_BUSY;
                    RD_BUSY: begin
                        if (i_busy) state_q <= RD_DONE;
                    end
                    RD_DONE: begin
                        if (i_data_out_valid) begin
                            rd_byte_q <= i_data_out[7:0];
                            rd_seen_q <= 1'b1;
                        end
                        if (!i_busy) begin
                            err_q          <= i_rxak | i_arb_lost | ~rd_ok_d;
                            rdata_q        <= rd_byte_d;
                            ack_q          <= grant_q;
                            arb_lost_clr_q <= i_arb_lost;
                            state_q        <= RESP;
                        end
                    end
                    RESP: begin
                        grant_q      <= '0;
                        err_q        <= 1'b0;
                        rdata_q      <= '0;
                        last_grant_q <= owner_q;
                        state_q      <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_grant        = grant_q;
    assign o_ack          = ack_q;
    assign o_rdata        = rdata_q;
    assign o_err          = err_q;
    assign o_mst_write    = mst_write_q;
    assign o_mst_read     = mst_read_q;
    assign o_slave_addr   = slave_addr_q;
    assign o_cmd_byte     = cmd_byte_q;
    assign o_num_bytes    = num_bytes_q;
    assign o_din          = din_q;
    assign o_arb_lost_clr = arb_lost_clr_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - scoreboard bench for i2c_master_arbiter
module tb_i2c_master_arbiter;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [2:0]  i_req, i_rw;
    logic [47:0] i_addr;
    logic [23:0] i_wdata;
    logic [2:0]  o_grant, o_ack;
    logic [7:0]  o_rdata, o_slave_addr, o_cmd_byte, o_num_bytes;
    logic        o_err, o_mst_write, o_mst_read, o_arb_lost_clr, o_soft_rst;
    logic [31:0] o_din, i_data_out;
    logic        i_busy, i_data_out_valid, i_rxak, i_arb_lost;

    i2c_master_arbiter #(.NUM_REQ(3), .DEV_ADDR_W(8'hC0), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .i_rst(i_rst), .i_req(i_req), .i_rw(i_rw), .i_addr(i_addr),
        .i_wdata(i_wdata), .o_grant(o_grant), .o_ack(o_ack), .o_rdata(o_rdata),
        .o_err(o_err), .o_mst_write(o_mst_write), .o_mst_read(o_mst_read),
        .o_slave_addr(o_slave_addr), .o_cmd_byte(o_cmd_byte), .o_num_bytes(o_num_bytes),
        .o_din(o_din), .i_busy(i_busy), .i_data_out_valid(i_data_out_valid),
        .i_data_out(i_data_out), .i_rxak(i_rxak), .i_arb_lost(i_arb_lost),
        .o_arb_lost_clr(o_arb_lost_clr), .o_soft_rst(o_soft_rst)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic rd; logic [7:0] sa; logic [7:0] cb; logic [7:0] nb; logic [31:0] din;
    } cmd_t;
    typedef struct packed {
        logic [2:0] ack; logic [7:0] rdata; logic err; logic alc; logic srst;
    } ack_t;

    cmd_t exp_cmd_q[$];
    ack_t exp_ack_q[$];
    cmd_t mon_ec;
    ack_t mon_ea;

    int tests_run = 0, tests_failed = 0;
    int n_wr = 0, n_rd = 0, n_ack = 0, n_srst = 0, n_alc = 0;
    int cyc = 0, issue_cyc = 0, ack_cyc = 0;

    int         mdl_busy_len = 20;
    bit         mdl_stuck = 0, mdl_nack_wr = 0, mdl_nack_rd = 0, mdl_arb = 0;
    logic [7:0] mdl_rdata = 8'h00;
    bit         mdl_is_rd;
    int         mdl_n;

    // I2C master model: busy a while after each command, optional read byte and error flags
    initial begin
        i_busy = 0; i_data_out_valid = 0; i_data_out = 0; i_rxak = 0; i_arb_lost = 0;
        forever begin
            @(posedge clk); #1;
            if (o_arb_lost_clr) i_arb_lost = 0;
            if ((o_mst_write || o_mst_read) && !i_rst) begin
                mdl_is_rd = o_mst_read;
                i_rxak = 0;
                @(posedge clk); #1;
                i_busy = 1;
                mdl_n = 0;
                while ((mdl_n < mdl_busy_len || mdl_stuck) && mdl_n < 5000) begin
                    @(posedge clk); #1;
                    mdl_n++;
                end
                if (mdl_is_rd) begin
                    i_data_out = {24'hABCDEF, mdl_rdata};
                    i_data_out_valid = 1;
                    @(posedge clk); #1;
                    i_data_out_valid = 0;
                end
                i_rxak = mdl_is_rd ? mdl_nack_rd : mdl_nack_wr;
                i_arb_lost = mdl_arb;
                i_busy = 0;
            end
        end
    end

    // Monitor: pops expected commands/acks as the DUT produces them
    always @(negedge clk) begin
        cyc++;
        if (!i_rst) begin
            tests_run++;
            if (!$onehot0(o_grant)) begin
                tests_failed++;
                $display("FAIL grant_onehot: o_grant=%b, required one-hot or zero", o_grant);
            end
            if (o_soft_rst) n_srst++;
            if (o_arb_lost_clr) n_alc++;
            if (o_mst_write || o_mst_read) begin
                if (o_mst_write) n_wr++;
                if (o_mst_read) n_rd++;
                issue_cyc = cyc;
                tests_run++;
                if (exp_cmd_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL cmd_unexpected: wr=%b rd=%b, required no command", o_mst_write, o_mst_read);
                end else begin
                    mon_ec = exp_cmd_q.pop_front();
                    if (o_mst_read !== mon_ec.rd || o_mst_write !== !mon_ec.rd ||
                        o_slave_addr !== mon_ec.sa || o_num_bytes !== mon_ec.nb ||
                        (!mon_ec.rd && (o_cmd_byte !== mon_ec.cb || o_din !== mon_ec.din))) begin
                        tests_failed++;
                        $display("FAIL cmd: got rd=%b wr=%b sa=%h cb=%h nb=%h din=%h, required rd=%b sa=%h cb=%h nb=%h din=%h",
                                 o_mst_read, o_mst_write, o_slave_addr, o_cmd_byte, o_num_bytes, o_din,
                                 mon_ec.rd, mon_ec.sa, mon_ec.cb, mon_ec.nb, mon_ec.din);
                    end
                end
            end
            if (o_ack != 3'b000) begin
                n_ack++;
                ack_cyc = cyc;
                tests_run++;
                if (exp_ack_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL ack_unexpected: o_ack=%b, required none", o_ack);
                end else begin
                    mon_ea = exp_ack_q.pop_front();
                    if (o_ack !== mon_ea.ack || o_rdata !== mon_ea.rdata || o_err !== mon_ea.err ||
                        o_arb_lost_clr !== mon_ea.alc || o_soft_rst !== mon_ea.srst || o_grant !== o_ack) begin
                        tests_failed++;
                        $display("FAIL ack: got ack=%b grant=%b rdata=%h err=%b clr=%b srst=%b, required ack=%b rdata=%h err=%b clr=%b srst=%b",
                                 o_ack, o_grant, o_rdata, o_err, o_arb_lost_clr, o_soft_rst,
                                 mon_ea.ack, mon_ea.rdata, mon_ea.err, mon_ea.alc, mon_ea.srst);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        i_rst = 1; i_req = 0;
        repeat (3) @(negedge clk);
        i_rst = 0;
        @(negedge clk);
    endtask

    task automatic wait_acks(input int k, input int budget, output bit ok);
        int seen = 0;
        int c = 0;
        while (seen < k && c < budget) begin
            @(negedge clk);
            c++;
            if (o_ack != 3'b000) seen++;
        end
        ok = (seen >= k);
    endtask

    task automatic test_reset();
        i_rst = 1; i_req = 3'b111; i_rw = 0; i_addr = 0; i_wdata = 0;
        repeat (4) @(negedge clk);
        tests_run++;
        if ({o_grant, o_ack, o_rdata, o_err, o_mst_write, o_mst_read, o_arb_lost_clr, o_soft_rst} !== 22'h0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: grant=%b ack=%b rdata=%h err=%b wr=%b rd=%b, required all 0",
                     o_grant, o_ack, o_rdata, o_err, o_mst_write, o_mst_read);
        end
        tests_run++;
        if ({o_slave_addr, o_cmd_byte, o_num_bytes, o_din} !== 56'h0) begin
            tests_failed++;
            $display("FAIL reset_cmd: sa=%h cb=%h nb=%h din=%h, required all 0",
                     o_slave_addr, o_cmd_byte, o_num_bytes, o_din);
        end
        i_req = 0; i_rst = 0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (o_grant !== 3'b000 || o_mst_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_req: grant=%b wr=%b, required 000/0", o_grant, o_mst_write);
        end
    endtask

    task automatic test_write();
        int w0, r0, a0;
        bit ok;
        do_reset();
        mdl_busy_len = 20;
        w0 = n_wr; r0 = n_rd; a0 = n_ack;
        exp_cmd_q.push_back('{1'b0, 8'hC0, 8'h35, 8'd2, 32'h00002A01});
        exp_ack_q.push_back('{3'b001, 8'h00, 1'b0, 1'b0, 1'b0});
        i_rw[0] = 0; i_addr[15:0] = 16'h3501; i_wdata[7:0] = 8'h2A; i_req[0] = 1;
        wait_acks(1, 300, ok);
        i_req[0] = 0;
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL write_timeout: no ack within 300 cycles, required ack"); end
        repeat (5) @(negedge clk);
        tests_run++;
        if (n_wr - w0 != 1 || n_rd != r0 || n_ack - a0 != 1) begin
            tests_failed++;
            $display("FAIL write_counts: wr=%0d rd=%0d ack=%0d, required 1/0/1", n_wr - w0, n_rd - r0, n_ack - a0);
        end
    endtask

    task automatic test_read();
        int w0, r0;
        bit ok;
        do_reset();
        mdl_busy_len = 15; mdl_rdata = 8'h92;
        w0 = n_wr; r0 = n_rd;
        exp_cmd_q.push_back('{1'b0, 8'hC0, 8'h30, 8'd1, 32'h0000000A});
        exp_cmd_q.push_back('{1'b1, 8'hC1, 8'h00, 8'd1, 32'h0});
        exp_ack_q.push_back('{3'b010, 8'h92, 1'b0, 1'b0, 1'b0});
        i_rw[1] = 1; i_addr[31:16] = 16'h300A; i_req[1] = 1;
        wait_acks(1, 300, ok);
        i_req[1] = 0;
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL read_timeout: no ack within 300 cycles, required ack"); end
        repeat (5) @(negedge clk);
        tests_run++;
        if (n_wr - w0 != 1 || n_rd - r0 != 1 || exp_cmd_q.size() != 0) begin
            tests_failed++;
            $display("FAIL read_counts: wr=%0d rd=%0d left=%0d, required 1/1/0", n_wr - w0, n_rd - r0, exp_cmd_q.size());
        end
    endtask

    task automatic test_fairness();
        int w0;
        bit ok;
        logic [7:0] kb;
        do_reset();
        mdl_busy_len = 3;
        w0 = n_wr;
        for (int k = 0; k < 3; k++) begin
            kb = 8'(k);
            i_rw[k] = 0;
            i_addr[16*k +: 16] = {8'h10 + kb, 8'h20 + kb};
            i_wdata[8*k +: 8] = 8'h40 + kb;
        end
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                kb = 8'(k);
                exp_cmd_q.push_back('{1'b0, 8'hC0, 8'h10 + kb, 8'd2, {16'h0, 8'h40 + kb, 8'h20 + kb}});
                exp_ack_q.push_back('{3'(1 << k), 8'h00, 1'b0, 1'b0, 1'b0});
            end
        end
        i_req = 3'b111;
        wait_acks(6, 600, ok);
        i_req = 3'b000;
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL fair_timeout: fewer than 6 acks in 600 cycles, required 6"); end
        repeat (5) @(negedge clk);
        tests_run++;
        if (n_wr - w0 != 6 || exp_ack_q.size() != 0) begin
            tests_failed++;
            $display("FAIL fair_counts: wr=%0d left=%0d, required 6/0", n_wr - w0, exp_ack_q.size());
        end
    endtask

    task automatic test_nack();
        int r0;
        bit ok;
        do_reset();
        mdl_busy_len = 8; mdl_nack_wr = 1;
        r0 = n_rd;
        exp_cmd_q.push_back('{1'b0, 8'hC0, 8'h12, 8'd1, 32'h00000034});
        exp_ack_q.push_back('{3'b100, 8'h00, 1'b1, 1'b0, 1'b0});
        i_rw[2] = 1; i_addr[47:32] = 16'h1234; i_req[2] = 1;
        wait_acks(1, 300, ok);
        i_req[2] = 0;
        mdl_nack_wr = 0;
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL nack_timeout: no ack within 300 cycles, required ack"); end
        repeat (5) @(negedge clk);
        tests_run++;
        if (n_rd != r0) begin
            tests_failed++;
            $display("FAIL nack_no_read: read pulses=%0d, required 0", n_rd - r0);
        end
    endtask

    task automatic test_arb_lost();
        int c0;
        bit ok;
        do_reset();
        mdl_busy_len = 6; mdl_arb = 1;
        c0 = n_alc;
        exp_cmd_q.push_back('{1'b0, 8'hC0, 8'h01, 8'd2, 32'h00005502});
        exp_ack_q.push_back('{3'b001, 8'h00, 1'b1, 1'b1, 1'b0});
        i_rw[0] = 0; i_addr[15:0] = 16'h0102; i_wdata[7:0] = 8'h55; i_req[0] = 1;
        wait_acks(1, 300, ok);
        i_req[0] = 0;
        mdl_arb = 0;
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL arb_timeout: no ack within 300 cycles, required ack"); end
        repeat (5) @(negedge clk);
        tests_run++;
        if (n_alc - c0 != 1) begin
            tests_failed++;
            $display("FAIL arb_clr_count: clr pulses=%0d, required 1", n_alc - c0);
        end
    endtask

    task automatic test_reset_mid();
        int a0, c;
        bit ok;
        do_reset();
        mdl_busy_len = 20; mdl_rdata = 8'h77;
        exp_cmd_q.push_back('{1'b0, 8'hC0, 8'h55, 8'd1, 32'h00000066});
        exp_cmd_q.push_back('{1'b1, 8'hC1, 8'h00, 8'd1, 32'h0});
        i_rw[0] = 1; i_addr[15:0] = 16'h5566; i_req[0] = 1;
        c = 0;
        while (!o_mst_read && c < 300) begin @(negedge clk); c++; end
        tests_run++;
        if (!o_mst_read) begin tests_failed++; $display("FAIL rstmid_no_read: read pulse not seen, required pulse"); end
        @(negedge clk);
        a0 = n_ack;
        i_rst = 1; i_req = 0;
        @(negedge clk);
        tests_run++;
        if ({o_grant, o_ack, o_err, o_mst_write, o_mst_read, o_slave_addr, o_num_bytes, o_din} !== 75'h0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: grant=%b ack=%b sa=%h nb=%h din=%h, required all 0",
                     o_grant, o_ack, o_slave_addr, o_num_bytes, o_din);
        end
        c = 0;
        while ((i_busy || c < 3) && c < 200) begin @(negedge clk); c++; end
        i_rst = 0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (n_ack != a0 || exp_cmd_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rstmid_ack: acks=%0d cmds_left=%0d, required 0/0", n_ack - a0, exp_cmd_q.size());
        end
        exp_cmd_q.push_back('{1'b0, 8'hC0, 8'h66, 8'd2, 32'h00008877});
        exp_ack_q.push_back('{3'b100, 8'h00, 1'b0, 1'b0, 1'b0});
        i_rw[2] = 0; i_addr[47:32] = 16'h6677; i_wdata[23:16] = 8'h88; i_req[2] = 1;
        wait_acks(1, 300, ok);
        i_req[2] = 0;
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL rstmid_req2: no ack within 300 cycles, required ack"); end
        repeat (5) @(negedge clk);
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        do_reset();
        mdl_stuck = 1;
        exp_cmd_q.push_back('{1'b0, 8'hC0, 8'h0A, 8'd2, 32'h0000CC0B});
        exp_ack_q.push_back('{3'b001, 8'h00, 1'b1, 1'b0, 1'b1});
        i_rw[0] = 0; i_addr[15:0] = 16'h0A0B; i_wdata[7:0] = 8'hCC; i_req[0] = 1;
        wait_acks(1, 400, ok);
        i_req[0] = 0;
        tests_run++;
        if (!ok || ack_cyc - issue_cyc > TMO + 1) begin
            tests_failed++;
            $display("FAIL timeout_latency: ok=%0d cycles=%0d, required ack within %0d", ok, ack_cyc - issue_cyc, TMO + 1);
        end
        mdl_stuck = 0;
        repeat (10) @(negedge clk);
    endtask
`else
    task automatic test_no_soft_rst();
        tests_run++;
        if (n_srst != 0) begin
            tests_failed++;
            $display("FAIL soft_rst_idle: pulses=%0d, required 0", n_srst);
        end
    endtask
`endif

    initial begin
        i_rst = 1; i_req = 0; i_rw = 0; i_addr = 0; i_wdata = 0;
        test_reset();
        test_write();
        test_read();
        test_fairness();
        test_nack();
        test_arb_lost();
        test_reset_mid();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_soft_rst();
`endif
        tests_run++;
        if (exp_cmd_q.size() != 0 || exp_ack_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: cmds=%0d acks=%0d left, required 0/0", exp_cmd_q.size(), exp_ack_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
